// File: rtl/hwa_seq_ctrl.sv
// Sequencer for the SC-FIR hardware weighted adder: LOAD pulse, 2^N-cycle RUN with LFSR R_y, result capture.
// Latency: request at T -> res_valid at T+2+2^N; optional HWA_LFSR_RESEED_EN reloads the LFSR on every LOAD.
// Backpressure: the result is held in RESULT until res_ready; no new request is accepted outside IDLE.
module hwa_seq_ctrl #(
    parameter int              N    = 8,
    parameter logic [N-1:0]    TAPS = 8'hB8,
    parameter logic [N-1:0]    SEED = 8'h01
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    output logic           hwa_start,
    output logic [N-1:0]   sel_bits,
    output logic [N-1:0]   R_y,
    input  logic [N:0]     hwa_out,
    input  logic           hwa_done,
    output logic           res_valid,
    output logic [N:0]     res_data,
    input  logic           res_ready,
    output logic           err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [N-1:0] SEL_LAST = {N{1'b1}};
    localparam logic [N-1:0] SEL_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   r_state;
    logic [N-1:0] r_sel;
    logic [N-1:0] r_lfsr;
    logic         r_res_vld;
    logic [N:0]   r_res_dat;
    logic         r_err;

    logic         w_last;
    logic         w_fb;

    assign w_last = (r_sel == SEL_LAST);
    assign w_fb   = ^(r_lfsr & TAPS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_lfsr    <= SEED;
            r_res_vld <= 1'b0;
            r_res_dat <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
`ifdef HWA_LFSR_RESEED_EN
                    r_lfsr <= SEED;
`else
                    r_lfsr <= r_lfsr;
`endif
                    r_sel   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_lfsr <= {r_lfsr[N-2:0], w_fb};
                    if (w_last) begin
                        // Capture happens on the last index even if the HWA's done flag disagrees.
                        r_sel     <= '0;
                        r_res_dat <= hwa_out;
                        r_res_vld <= 1'b1;
                        r_state   <= S_RESULT;
                        if (!hwa_done) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_sel <= r_sel + SEL_ONE;
                        if (hwa_done) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_vld <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign hwa_start = (r_state == S_LOAD);
    assign sel_bits  = r_sel;
    assign R_y       = r_lfsr;
    assign res_valid = r_res_vld;
    assign res_data  = r_res_dat;
    assign err       = r_err;

endmodule

// File: tb/tb_hwa_seq_ctrl.sv
// Bench for hwa_seq_ctrl at N=4, TAPS=4'hC, SEED=4'h1 with a simple HWA stub.
// Results are checked by a scoreboard monitor; cycle-level control outputs are checked by the stimulus.
module tb_hwa_seq_ctrl;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           hwa_start;
    logic [N-1:0]   sel_bits;
    logic [N-1:0]   R_y;
    logic [N:0]     hwa_out;
    logic           hwa_done;
    logic           res_valid;
    logic [N:0]     res_data;
    logic           res_ready;
    logic           err;

    logic [N:0]     stub_val;
    bit             inject;

    hwa_seq_ctrl #(.N(4), .TAPS(4'hC), .SEED(4'h1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .hwa_start (hwa_start),
        .sel_bits  (sel_bits),
        .R_y       (R_y),
        .hwa_out   (hwa_out),
        .hwa_done  (hwa_done),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .err       (err)
    );

    always #5 clock = ~clock;

    // HWA stub: count presented as a constant, done on the last index (plus a bad early done when injected).
    assign hwa_out  = stub_val;
    assign hwa_done = (sel_bits == 4'hF) || (inject && sel_bits == 4'h7);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N:0] dat;
        int         rise;
    } exp_t;
    exp_t exp_q[$];

    // Hand-derived x^4+x^3+1 sequence from seed 1 (period 15).
    logic [N-1:0] ry_tbl [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                  4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    int lfsr_idx = 0;
    bit exp_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic prev_vld = 1'b0;
    exp_t mon_e;
    always @(negedge clock) begin
        if (res_valid === 1'b1 && prev_vld !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: res_valid rose with no pending request (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data_at_rise", 32'(res_data), 32'(mon_e.dat));
                check("res_valid_rise_cycle", cyc, mon_e.rise);
            end
        end
        prev_vld = res_valid;
    end

    task automatic do_run(input logic [N:0] val, input int hold, input bit inj);
        int t;
        int start;
        stub_val = val;
        inject   = inj;
`ifdef HWA_LFSR_RESEED_EN
        start = 0;
`else
        start = lfsr_idx;
`endif
        check("req_ready_idle", req_ready, 1);
        t = cyc;
        req_valid = 1'b1;
        exp_q.push_back('{val, t + 18});
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("load_hwa_start", hwa_start, 1);
        check("load_req_ready", req_ready, 0);
        check("load_sel_bits", sel_bits, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            check("run_sel_bits", sel_bits, i);
            check("run_R_y", R_y, ry_tbl[(start + i) % 15]);
            check("run_hwa_start", hwa_start, 0);
        end
        lfsr_idx = (start + 16) % 15;
        if (inj) exp_err = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", 32'(res_data), 32'(val));
            check("hold_req_ready", req_ready, 0);
            check("hold_sel_bits", sel_bits, 0);
            check("hold_err", err, exp_err);
        end
        res_ready = 1'b1;
        @(negedge clock);
        check("ack_res_valid", res_valid, 0);
        check("ack_req_ready", req_ready, 1);
        res_ready = 1'b0;
    endtask

    task automatic do_abort();
        inject   = 1'b0;
        stub_val = 5'd0;
        check("abort_req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        @(negedge clock);
        check("abort_load_hwa_start", hwa_start, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("held_req_sel_bits", sel_bits, i);
            check("held_req_hwa_start", hwa_start, 0);
            check("held_req_req_ready", req_ready, 0);
        end
        check("err_sticky_before_reset", err, exp_err);
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clock);
        check("abort_sel_bits", sel_bits, 0);
        check("abort_hwa_start", hwa_start, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_R_y", R_y, 1);
        check("abort_req_ready", req_ready, 1);
        check("abort_err", err, 0);
        reset    = 1'b0;
        lfsr_idx = 0;
        exp_err  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        stub_val  = '0;
        inject    = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_req_ready", req_ready, 1);
        check("rst_hwa_start", hwa_start, 0);
        check("rst_sel_bits", sel_bits, 0);
        check("rst_R_y", R_y, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        @(negedge clock);

        do_run(5'd9, 5, 1'b0);
        do_run(5'd3, 1, 1'b0);
        do_run(5'd12, 2, 1'b1);
        do_run(5'd16, 1, 1'b0);
        do_abort();
        do_run(5'd7, 1, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hwa_seq_ctrl.md
Name: hwa_seq_ctrl

Overview:
Sequencer and initiator for a stochastic-computing hardware weighted adder (HWA) in the SC FIR datapath. It accepts one evaluation request and drives the HWA control inputs: the start pulse, the sel_bits cycle counter and the LFSR-generated comparator random number R_y. It captures the HWA binary count when the HWA signals done and returns that count to the downstream consumer with a valid/ready handshake.

Parameters:
N, 8, stream precision; one evaluation runs 2^N stream cycles; R_y and sel_bits are N bits wide.
TAPS, 8'hB8, LFSR feedback mask, N bits; the default is x^8+x^6+x^5+x^4+1 (maximal length).
SEED, 8'h01, LFSR seed, N bits; must be nonzero.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request for a new HWA evaluation
req_ready  out  1  high only in IDLE
hwa_start  out  1  one-cycle pulse that clears the HWA accumulator
sel_bits  out  N  cycle index to the HWA mux tree
R_y  out  N  random number to the HWA comparators
hwa_out  in  N+1  HWA running count
hwa_done  in  1  HWA done flag (high when sel_bits == 2^N-1)
res_valid  out  1  result available
res_data  out  N+1  captured count
res_ready  in  1  consumer accepts the result
err  out  1  sticky protocol error

Behaviour:
- Reset values: FSM = IDLE, sel_bits = 0, R_y = SEED, lfsr = SEED, hwa_start = 0, res_valid = 0, res_data = 0, err = 0.
- Reset applies in any state, including mid-RUN. The run is abandoned, no result is produced, and err is cleared.
- States: IDLE, LOAD, RUN, RESULT.
- IDLE:
  - req_ready = 1.
  - req_valid=1 -> go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - hwa_start = 1 and sel_bits = 0.
  - LFSR handling per the optional feature.
  - Next state is RUN.
- RUN (exactly 2^N cycles):
  - sel_bits counts 0,1,...,2^N-1, incrementing once per cycle.
  - R_y = lfsr. lfsr advances every RUN cycle: lfsr <= {lfsr[N-2:0], ^(lfsr & TAPS)}.
  - R_y is never 0. Period is 2^N-1, so R_y in cycle 2^N-1 equals R_y in cycle 0.
- Capture, in the RUN cycle where sel_bits == 2^N-1:
  - res_data <= hwa_out, the count accumulated over sel 0..2^N-2.
  - res_valid <= 1, then go to RESULT.
  - sel_bits wraps to 0.
- RESULT:
  - res_valid = 1 and res_data is held stable.
  - res_valid & res_ready -> next cycle res_valid = 0 and state = IDLE.
  - Without res_ready, stay in RESULT with no timeout.
- req_valid is ignored outside IDLE; req_ready = 0 there. There is no request queueing.
- Latency: request accepted at cycle T -> LOAD at T+1 -> RUN from T+2 to T+1+2^N -> res_valid first high at T+2+2^N.
- err is set (sticky until reset) when either:
  - hwa_done=1 in a RUN cycle with sel_bits != 2^N-1, or
  - hwa_done=0 in the capture cycle.
- Capture still occurs on sel_bits == 2^N-1 regardless of hwa_done.
- hwa_start is high only in LOAD. sel_bits is 0 outside RUN.

Optional Feature:
Macro HWA_LFSR_RESEED_EN.
- Defined: lfsr is reloaded with SEED in LOAD. Every evaluation uses the identical R_y sequence, so results are deterministic and repeatable.
- Undefined: lfsr keeps its state across evaluations (loaded only at reset). Successive evaluations use different R_y windows, which decorrelates repeated streams.

Test Plan (N=4, TAPS=4'hC, SEED=4'h1):
- Reset, then req_valid pulse at cycle T -> req_ready falls at T+1; hwa_start=1 only at T+1; sel_bits 0..15 during T+2..T+17; res_valid rises at T+18.
- Check R_y during RUN cycles 0..5 -> 1,2,4,9,3,6.
- HWA stub drives hwa_out=9 when sel_bits=15 -> res_data=9. Hold res_ready=0 for 5 cycles -> res_valid and res_data stable. res_ready=1 -> res_valid=0 next cycle, and req_ready=1 then.
- Two back-to-back requests with the macro defined -> both runs show identical R_y sequences starting at 1. Macro undefined -> the second run starts at R_y=2 (lfsr state after 16 advances), not 1.
- Stub asserts hwa_done at sel_bits=7 -> err=1 and stays 1 through the following evaluation. Reset -> err=0.
- Assert reset at RUN sel_bits=5 -> next cycle state IDLE, sel_bits=0, hwa_start=0, res_valid=0, R_y=1. req_valid held high throughout RUN is ignored (no restart).
